trade_order_ctrl: RTL and testbench
===================================

# trade_order_ctrl

Order-issue controller sitting downstream of the trading logic unit. Takes the registered buy/sell decision and its valid strobe, arbitrates conflicting or disallowed signals, and issues single orders over a valid/ready handshake to the order-entry interface. Tracks net signed position against a configurable limit and enforces a post-order cooldown so the strategy pipeline cannot flood the exchange path.

## Interface
- MAX_POS, 8: absolute net position limit; position range is -MAX_POS..+MAX_POS
- COOLDOWN, 4: idle cycles enforced after each completed or aborted order; 0 disables cooldown
- TIMEOUT, 16: maximum cycles order_valid may stay high awaiting order_ready (used only with ORDER_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  when 0, new signals are ignored (not counted as drops); an in-flight order still completes
- sig_valid  in  1  strobe qualifying buy_in/sell_in/price_in for one cycle
- buy_in  in  1  buy decision
- sell_in  in  1  sell decision
- price_in  in  8  price at decision time
- order_valid  out  1  order offered
- order_side  out  1  1 = buy, 0 = sell
- order_price  out  8  latched price
- order_ready  in  1  downstream accepts order when high with order_valid
- position  out  8  signed two's-complement net position
- busy  out  1  high whenever state is not IDLE
- drop_count  out  8  saturating count of rejected signals (saturates at 255)
- timeout_flag  out  1  one-cycle pulse on order abort; constant 0 without ORDER_TIMEOUT_EN

## Operation
- States: IDLE, ISSUE, COOL.
- IDLE, sig_valid=1, enable=1:
  - buy_in^sell_in=1 and limit allows (buy: position < MAX_POS; sell: position > -MAX_POS): latch side and price, go to ISSUE.
  - buy_in=sell_in=1 (conflict), or limit would be exceeded: drop_count+1, stay in IDLE.
  - buy_in=sell_in=0: no action.
- ISSUE: order_valid=1; order_side and order_price remain stable until the handshake. When order_valid&order_ready: position ±1 (buy +1, sell -1), go to COOL (or IDLE if COOLDOWN=0).
- COOL: down-counter loaded with COOLDOWN; go to IDLE when it expires.
- sig_valid with buy_in|sell_in while in ISSUE or COOL, with enable=1: drop_count+1; the signal is not queued.
- Position never leaves [-MAX_POS, +MAX_POS].
- rst mid-order: order_valid drops at the next edge; position and counters clear; nothing is carried over.
- Reset values: order_valid=0, order_side=0, order_price=0, position=0, busy=0, drop_count=0, timeout_flag=0, state=IDLE.

## Timing
- Signal accepted in cycle N: order_valid=1 and busy=1 from cycle N+1.
- Handshake in cycle M: from cycle M+1, order_valid=0 and position updated. State is COOL for cycles M+1..M+COOLDOWN and IDLE at M+COOLDOWN+1. A sig_valid in cycle M+COOLDOWN+1 is accepted.
- order_ready high in the same cycle order_valid first rises: handshake completes in that cycle, so there is one order_valid cycle.
- drop_count updates one cycle after the rejected sig_valid.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ORDER_TIMEOUT_EN defined: a counter runs while in ISSUE. order_valid stays high for at most TIMEOUT cycles, and a handshake in the TIMEOUT-th cycle succeeds. If there is no handshake by then, at the next edge: order_valid=0, timeout_flag=1 for one cycle, drop_count+1, position unchanged, enter COOL.
- ORDER_TIMEOUT_EN undefined: ISSUE waits indefinitely, and timeout_flag is tied to 0.

## Test plan
- Reset, then sig_valid with buy=1 and price 0x40, order_ready held 1: order_valid high for exactly one cycle with side=1 and price=0x40; position=1; busy returns low 4 cycles after the handshake.
- buy=sell=1 with sig_valid: no order is issued; drop_count=1.
- 8 accepted buys with ready=1 and cooldown respected, then a 9th buy: position=8, the 9th is dropped (drop_count=1), and a following sell is accepted giving position=7.
- Buy accepted, order_ready held 0 for 5 cycles and sig_valid sell pulsed during ISSUE: order_side and order_price stay stable, the sell is dropped, and the handshake on cycle 6 sets position=1.
- ORDER_TIMEOUT_EN, TIMEOUT=16, order_ready held 0: order_valid high 16 cycles, then timeout_flag pulses once, position=0, drop_count=1.
- rst asserted while order_valid=1 and position=3: next cycle all outputs are at their reset values.

Source files
------------

// File: rtl/trade_order_ctrl.sv
// rtl/trade_order_ctrl.sv - order-issue controller with position limit, cooldown and drop counting
// Optional ISSUE-state watchdog enabled by defining ORDER_TIMEOUT_EN.
module trade_order_ctrl #(
  parameter int MAX_POS  = 8,
  parameter int COOLDOWN = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sig_valid,
  input  logic       buy_in,
  input  logic       sell_in,
  input  logic [7:0] price_in,
  output logic       order_valid,
  output logic       order_side,
  output logic [7:0] order_price,
  input  logic       order_ready,
  output logic [7:0] position,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;

  localparam logic signed [7:0] POS_MAX = 8'(MAX_POS);
  localparam logic signed [7:0] POS_MIN = -POS_MAX;

  state_t      state, state_nxt;
  logic [15:0] cool_cnt;
  logic        new_sig, one_side, lim_ok;
  logic        accept, reject, handshake, expire;
  logic        order_valid_nxt, busy_nxt;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  assign new_sig   = sig_valid & enable;
  assign one_side  = buy_in ^ sell_in;
  assign lim_ok    = buy_in ? ($signed(position) < POS_MAX) : ($signed(position) > POS_MIN);
  assign accept    = (state == IDLE) && new_sig && one_side && lim_ok;
  // Signals arriving while an order is outstanding or cooling down are discarded, not queued.
  assign reject    = new_sig && ((state == IDLE) ? ((buy_in & sell_in) || (one_side && !lim_ok))
                                                 : (buy_in | sell_in));
  assign handshake = (state == ISSUE) && order_ready;

`ifdef ORDER_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign expire = (state == ISSUE) && !order_ready && (to_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (state == ISSUE)
      to_cnt <= to_cnt + 16'd1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (handshake || expire) state_nxt = (COOLDOWN == 0) ? IDLE : COOL;
      COOL:    if (cool_cnt == 16'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they leave the flops aligned with state.
  always_comb begin
    order_valid_nxt = (state_nxt == ISSUE);
    busy_nxt        = (state_nxt != IDLE);
  end

  assign drop_inc = {1'b0, reject} + {1'b0, expire};
  assign drop_sum = {1'b0, drop_count} + {7'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      order_valid  <= 1'b0;
      order_side   <= 1'b0;
      order_price  <= 8'd0;
      position     <= 8'd0;
      busy         <= 1'b0;
      drop_count   <= 8'd0;
      timeout_flag <= 1'b0;
      cool_cnt     <= 16'd0;
    end else begin
      order_valid  <= order_valid_nxt;
      busy         <= busy_nxt;
      timeout_flag <= expire;
      drop_count   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (accept) begin
        order_side  <= buy_in;
        order_price <= price_in;
      end
      if (handshake)
        position <= order_side ? position + 8'd1 : position - 8'd1;
      if (state_nxt == COOL && state != COOL)
        cool_cnt <= 16'(COOLDOWN - 1);
      else if (state == COOL && cool_cnt != 16'd0)
        cool_cnt <= cool_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_trade_order_ctrl.sv
// tb/tb_trade_order_ctrl.sv - directed self-checking bench for trade_order_ctrl
module tb_trade_order_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, sig_valid, buy_in, sell_in, order_ready;
  logic [7:0] price_in;
  logic       order_valid, order_side, busy, timeout_flag;
  logic [7:0] order_price, position, drop_count;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  trade_order_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .sig_valid(sig_valid),
    .buy_in(buy_in), .sell_in(sell_in), .price_in(price_in),
    .order_valid(order_valid), .order_side(order_side), .order_price(order_price),
    .order_ready(order_ready), .position(position), .busy(busy),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sig_valid = 1'b0; buy_in = 1'b0; sell_in = 1'b0;
    price_in = 8'd0; order_ready = 1'b0; enable = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_sig(input logic b, input logic s, input logic [7:0] p);
    sig_valid = 1'b1; buy_in = b; sell_in = s; price_in = p;
    tick();
    sig_valid = 1'b0; buy_in = 1'b0; sell_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n); end
  endtask

  task automatic do_order(input logic b, input logic [7:0] p);
    order_ready = 1'b1;
    send_sig(b, ~b, p);
    wait_idle();
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (order_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", order_valid); end
    vec_cnt++; if (order_side !== 1'b0) begin err_cnt++; $display("FAIL rst_side: got %b want 0", order_side); end
    vec_cnt++; if (order_price !== 8'h00) begin err_cnt++; $display("FAIL rst_price: got %h want 00", order_price); end
    vec_cnt++; if (position !== 8'h00) begin err_cnt++; $display("FAIL rst_pos: got %h want 00", position); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec_cnt++; if (drop_count !== 8'h00) begin err_cnt++; $display("FAIL rst_drop: got %h want 00", drop_count); end
    vec_cnt++; if (timeout_flag !== 1'b0) begin err_cnt++; $display("FAIL rst_tflag: got %b want 0", timeout_flag); end
  endtask

  task automatic test_single_buy();
    do_reset();
    order_ready = 1'b1;
    send_sig(1'b1, 1'b0, 8'h40);
    vec_cnt++; if (order_valid !== 1'b1) begin err_cnt++; $display("FAIL buy_valid: got %b want 1", order_valid); end
    vec_cnt++; if (order_side !== 1'b1) begin err_cnt++; $display("FAIL buy_side: got %b want 1", order_side); end
    vec_cnt++; if (order_price !== 8'h40) begin err_cnt++; $display("FAIL buy_price: got %h want 40", order_price); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL buy_busy: got %b want 1", busy); end
    tick();
    vec_cnt++; if (order_valid !== 1'b0) begin err_cnt++; $display("FAIL buy_one_cycle: got %b want 0", order_valid); end
    vec_cnt++; if (position !== 8'h01) begin err_cnt++; $display("FAIL buy_pos: got %h want 01", position); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL cool_busy[%0d]: got %b want 1", i, busy); end
    end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL cool_end: got %b want 0", busy); end
    order_ready = 1'b0;
    send_sig(1'b0, 1'b1, 8'h41);
    vec_cnt++; if (order_valid !== 1'b1) begin err_cnt++; $display("FAIL accept_after_cool: got %b want 1", order_valid); end
    vec_cnt++; if (order_side !== 1'b0) begin err_cnt++; $display("FAIL sell_side: got %b want 0", order_side); end
  endtask

  task automatic test_conflict();
    do_reset();
    order_ready = 1'b1;
    send_sig(1'b1, 1'b1, 8'h55);
    vec_cnt++; if (order_valid !== 1'b0) begin err_cnt++; $display("FAIL conflict_valid: got %b want 0", order_valid); end
    vec_cnt++; if (drop_count !== 8'h01) begin err_cnt++; $display("FAIL conflict_drop: got %h want 01", drop_count); end
    send_sig(1'b0, 1'b0, 8'h55);
    vec_cnt++; if (drop_count !== 8'h01 || busy !== 1'b0) begin err_cnt++; $display("FAIL noop_sig: drop=%h busy=%b want 01/0", drop_count, busy); end
    enable = 1'b0;
    send_sig(1'b1, 1'b0, 8'h56);
    vec_cnt++; if (busy !== 1'b0 || drop_count !== 8'h01) begin err_cnt++; $display("FAIL disabled: busy=%b drop=%h want 0/01", busy, drop_count); end
    enable = 1'b1;
  endtask

  task automatic test_limit();
    do_reset();
    for (int i = 0; i < 8; i++) do_order(1'b1, 8'(i));
    vec_cnt++; if (position !== 8'h08) begin err_cnt++; $display("FAIL limit_pos: got %h want 08", position); end
    send_sig(1'b1, 1'b0, 8'h99);
    vec_cnt++; if (order_valid !== 1'b0) begin err_cnt++; $display("FAIL limit_valid: got %b want 0", order_valid); end
    vec_cnt++; if (drop_count !== 8'h01) begin err_cnt++; $display("FAIL limit_drop: got %h want 01", drop_count); end
    do_order(1'b0, 8'h20);
    vec_cnt++; if (position !== 8'h07) begin err_cnt++; $display("FAIL limit_sell_pos: got %h want 07", position); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    send_sig(1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (order_valid !== 1'b1 || order_side !== 1'b1 || order_price !== 8'h77) begin
        err_cnt++;
        $display("FAIL bp_stable[%0d]: valid=%b side=%b price=%h want 1/1/77", i, order_valid, order_side, order_price);
      end
      if (i == 1) begin sig_valid = 1'b1; sell_in = 1'b1; price_in = 8'h12; end
      tick();
      sig_valid = 1'b0; sell_in = 1'b0;
    end
    vec_cnt++; if (order_valid !== 1'b1 || order_price !== 8'h77) begin err_cnt++; $display("FAIL bp_cycle6: valid=%b price=%h want 1/77", order_valid, order_price); end
    order_ready = 1'b1;
    tick();
    vec_cnt++; if (order_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_done: got %b want 0", order_valid); end
    vec_cnt++; if (position !== 8'h01) begin err_cnt++; $display("FAIL bp_pos: got %h want 01", position); end
    vec_cnt++; if (drop_count !== 8'h01) begin err_cnt++; $display("FAIL bp_drop: got %h want 01", drop_count); end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    send_sig(1'b1, 1'b0, 8'h33);
`ifdef ORDER_TIMEOUT_EN
    while (order_valid && n < 40) begin tick(); n++; end
    vec_cnt++; if (n != 16) begin err_cnt++; $display("FAIL to_len: got %0d cycles want 16", n); end
    vec_cnt++; if (timeout_flag !== 1'b1) begin err_cnt++; $display("FAIL to_flag: got %b want 1", timeout_flag); end
    vec_cnt++; if (position !== 8'h00) begin err_cnt++; $display("FAIL to_pos: got %h want 00", position); end
    vec_cnt++; if (drop_count !== 8'h01) begin err_cnt++; $display("FAIL to_drop: got %h want 01", drop_count); end
    tick();
    vec_cnt++; if (timeout_flag !== 1'b0) begin err_cnt++; $display("FAIL to_pulse: got %b want 0", timeout_flag); end
`else
    for (int i = 0; i < 20; i++) begin
      vec_cnt++; if (timeout_flag !== 1'b0) begin err_cnt++; $display("FAIL no_to_flag[%0d]: got %b want 0", i, timeout_flag); end
      tick();
    end
    vec_cnt++; if (order_valid !== 1'b1) begin err_cnt++; $display("FAIL no_to_wait: got %b want 1", order_valid); end
    order_ready = 1'b1;
    tick();
    vec_cnt++; if (position !== 8'h01 || order_valid !== 1'b0) begin err_cnt++; $display("FAIL no_to_done: pos=%h valid=%b want 01/0", position, order_valid); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) do_order(1'b1, 8'h10);
    order_ready = 1'b0;
    send_sig(1'b1, 1'b0, 8'hAB);
    send_sig(1'b1, 1'b1, 8'hAC);
    vec_cnt++; if (order_valid !== 1'b1 || position !== 8'h03) begin err_cnt++; $display("FAIL mid_pre: valid=%b pos=%h want 1/03", order_valid, position); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_cnt++;
    if (order_valid !== 1'b0 || order_side !== 1'b0 || order_price !== 8'h00 || position !== 8'h00 ||
        busy !== 1'b0 || drop_count !== 8'h00 || timeout_flag !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_rst: valid=%b side=%b price=%h pos=%h busy=%b drop=%h tflag=%b want all 0",
               order_valid, order_side, order_price, position, busy, drop_count, timeout_flag);
    end
    tick();
    vec_cnt++; if (busy !== 1'b0 || order_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_no_carry: busy=%b valid=%b want 0/0", busy, order_valid); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; sig_valid = 1'b0; buy_in = 1'b0; sell_in = 1'b0;
    price_in = 8'd0; order_ready = 1'b0;
    test_reset();
    test_single_buy();
    test_conflict();
    test_limit();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
